// File: rtl/pwm_ctrl_pkg.sv
// Shared PWM control types and default widths.
// Used by the ramp sequencer and the PWM generator.
package pwm_ctrl_pkg;

  localparam int PWM_DUTY_W  = 8;
  localparam int PWM_STEP_W  = 4;
  localparam int PWM_PRESC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_FAULT = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/pwm_ramp_tick.sv
// Ramp-tick prescaler: one-cycle tick every presc+1 cycles.
// clr restarts the count so a new command gets a full interval.
module pwm_ramp_tick
  import pwm_ctrl_pkg::*;
#(
  parameter int PRESC_W = PWM_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  assign tick = (cnt_q == presc);

  // count up, wrap on tick or restart on clear
  always_comb begin
    cnt_d = cnt_q + PRESC_W'(1);
    if (clr || tick) cnt_d = '0;
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty ramp sequencer in front of the PWM generator.
// Optional command watchdog: define PWM_RAMP_WDOG_EN.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int          DUTY_W      = PWM_DUTY_W,
  parameter int          STEP_W      = PWM_STEP_W,
  parameter int          PRESC_W     = PWM_PRESC_W,
  parameter logic [23:0] WDOG_CYCLES = 24'd10_000_000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic [DUTY_W-1:0]  CMD_DUTY,
  input  logic [STEP_W-1:0]  CMD_STEP,
  input  logic [PRESC_W-1:0] PRESC,
  input  logic               PERIOD_START,
  input  logic               FAULT,
  input  logic               FAULT_CLR,
  output logic [DUTY_W-1:0]  DUTY,
  output logic               BUSY,
  output logic               FAULT_ACT,
  output logic               WDOG_TRIP
);

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] cur_q, cur_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              fact_q, fact_d;

  logic              accept;
  logic              tick;
  logic              wdog_fire;

  logic [DUTY_W:0]   cur_x, tgt_x, stp_x;
  logic [DUTY_W:0]   up_x, dn_x, lo_x;
  logic [DUTY_W-1:0] ramp_nxt;

  assign accept    = CMD_VALID && ready_q;
  assign CMD_READY = ready_q;
  assign DUTY      = duty_q;
  assign BUSY      = busy_q;
  assign FAULT_ACT = fact_q;

  pwm_ramp_tick #(
    .PRESC_W (PRESC_W)
  ) u_tick (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (accept),
    .presc (PRESC),
    .tick  (tick)
  );

`ifdef PWM_RAMP_WDOG_EN
  logic [23:0] wdog_q, wdog_d;
  logic        trip_q, trip_d;
  logic        wdog_hold;

  assign wdog_hold = FAULT || (state_q == ST_FAULT);
  assign wdog_fire = !wdog_hold && !accept
                  && (wdog_q == WDOG_CYCLES - 24'd1)
                  && (tgt_q != '0);
  assign WDOG_TRIP = trip_q;

  // command-silence counter and sticky trip flag
  always_comb begin
    wdog_d = wdog_q;
    trip_d = trip_q;
    if (wdog_hold) begin
      wdog_d = wdog_q;
    end else if (accept) begin
      wdog_d = '0;
      trip_d = 1'b0;
    end else if (wdog_q == WDOG_CYCLES - 24'd1) begin
      wdog_d = '0;
      if (wdog_fire) trip_d = 1'b1;
    end else begin
      wdog_d = wdog_q + 24'd1;
    end
  end

  // watchdog registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdog_q <= '0;
      trip_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      trip_q <= trip_d;
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_fire   = 1'b0;
  assign WDOG_TRIP   = 1'b0;
`endif

  // one ramp step toward tgt, clamped; extra bit avoids wrap
  always_comb begin
    cur_x = {1'b0, cur_q};
    tgt_x = {1'b0, tgt_q};
    stp_x = (DUTY_W+1)'(step_q);
    up_x  = cur_x + stp_x;
    dn_x  = tgt_x + stp_x;
    lo_x  = cur_x - stp_x;
    if (cur_q < tgt_q) begin
      ramp_nxt = (up_x > tgt_x) ? tgt_q : up_x[DUTY_W-1:0];
    end else begin
      ramp_nxt = (cur_x > dn_x) ? lo_x[DUTY_W-1:0] : tgt_q;
    end
  end

  // FSM next state, working duty and period-aligned commit
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    duty_d  = duty_q;
    if (PERIOD_START) duty_d = cur_q;
    if (FAULT) begin
      state_d = ST_FAULT;
      cur_d   = '0;
      tgt_d   = '0;
      duty_d  = '0;
    end else begin
      unique case (state_q)
        ST_FAULT: begin
          if (FAULT_CLR) state_d = ST_IDLE;
        end
        default: begin
          if (accept) begin
            tgt_d  = CMD_DUTY;
            step_d = CMD_STEP;
            if (CMD_STEP == '0) cur_d = CMD_DUTY;
            state_d = (cur_d == CMD_DUTY) ? ST_IDLE : ST_RAMP;
          end else if (wdog_fire) begin
            tgt_d   = '0;
            step_d  = (step_q == '0) ? STEP_W'(1) : step_q;
            state_d = (cur_q == '0) ? ST_IDLE : ST_RAMP;
          end else if (state_q == ST_RAMP) begin
            if (tick) cur_d = ramp_nxt;
            if (cur_d == tgt_q) state_d = ST_IDLE;
          end
        end
      endcase
    end
    ready_d = (state_d != ST_FAULT);
    fact_d  = (state_d == ST_FAULT);
    busy_d  = (state_d == ST_RAMP) || (cur_d != duty_d);
  end

  // state and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      duty_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      fact_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      duty_q  <= duty_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fact_q  <= fact_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl.
// Watchdog scenario compiled in with PWM_RAMP_WDOG_EN.
module tb_pwm_ramp_ctrl;

`ifdef PWM_RAMP_WDOG_EN
  localparam logic [23:0] TB_WDOG = 24'd100;
`else
  localparam logic [23:0] TB_WDOG = 24'd10_000_000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_duty;
  logic [3:0]  cmd_step;
  logic [15:0] presc;
  logic        ps;
  logic        fault;
  logic        fault_clr;
  logic [7:0]  duty;
  logic        busy;
  logic        fault_act;
  logic        wdog_trip;

  int n_pass  = 0;
  int n_total = 0;
  int m_cur   = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .DUTY_W      (8),
    .STEP_W      (4),
    .PRESC_W     (16),
    .WDOG_CYCLES (TB_WDOG)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .CMD_VALID    (cmd_valid),
    .CMD_READY    (cmd_ready),
    .CMD_DUTY     (cmd_duty),
    .CMD_STEP     (cmd_step),
    .PRESC        (presc),
    .PERIOD_START (ps),
    .FAULT        (fault),
    .FAULT_CLR    (fault_clr),
    .DUTY         (duty),
    .BUSY         (busy),
    .FAULT_ACT    (fault_act),
    .WDOG_TRIP    (wdog_trip)
  );

  // working duty after j ramp-clock edges following the accept edge
  function automatic int exp_cur(int c0, int tgt, int stp,
                                 int p, int j);
    int k;
    if (j < 0) return c0;
    if (stp == 0) return tgt;
    k = j / (p + 1);
    if (tgt >= c0) return (c0 + k*stp > tgt) ? tgt : c0 + k*stp;
    return (c0 - k*stp < tgt) ? tgt : c0 - k*stp;
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // issue one command with PERIOD_START held high so DUTY shows
  // the working duty one cycle late; check every cycle
  task automatic do_ramp(input int tgt, input int stp,
                         input int p, input int stop);
    int c0, d, n, last, e, ex;
    c0 = m_cur;
    d  = (tgt > c0) ? tgt - c0 : c0 - tgt;
    n  = (stp == 0) ? 0 : (d + stp - 1) / stp;
    last = n * (p + 1);
    e  = (stop < last + 2) ? stop : last + 2;
    cmd_valid = 1'b1;
    cmd_duty  = 8'(tgt);
    cmd_step  = 4'(stp);
    presc     = 16'(p);
    for (int j = 0; j <= e; j++) begin
      step_clk();
      if (j == 0) cmd_valid = 1'b0;
      ex = exp_cur(c0, tgt, stp, p, j - 1);
      n_total++;
      if (duty !== 8'(ex))
        $display("FAIL ramp_duty t=%0d j=%0d got %0d exp %0d",
                 tgt, j, duty, ex);
      else n_pass++;
    end
    m_cur = exp_cur(c0, tgt, stp, p, e);
    if (e == last + 2) begin
      n_total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1)
        $display("FAIL ramp_settle busy=%b rdy=%b exp 0/1",
                 busy, cmd_ready);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_duty = '0;
    cmd_step = '0; presc = '0; ps = 1'b0;
    fault = 1'b0; fault_clr = 1'b0;
    #12;
    n_total++;
    if ({duty, cmd_ready, busy, fault_act, wdog_trip}
        !== {8'd0, 4'b1000})
      $display("FAIL reset_vals d=%0d r=%b b=%b f=%b w=%b",
               duty, cmd_ready, busy, fault_act, wdog_trip);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ps = i[0];
      step_clk();
      n_total++;
      if (duty !== 8'd0 || cmd_ready !== 1'b1 || busy !== 1'b0)
        $display("FAIL post_reset d=%0d r=%b b=%b exp 0/1/0",
                 duty, cmd_ready, busy);
      else n_pass++;
    end
    ps = 1'b0;
  endtask

  task automatic test_jump();
    cmd_valid = 1'b1; cmd_duty = 8'd200; cmd_step = 4'd0;
    step_clk();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (duty !== 8'd0 || busy !== 1'b1)
        $display("FAIL jump_hold i=%0d d=%0d b=%b exp 0/1",
                 i, duty, busy);
      else n_pass++;
      if (i < 4) step_clk();
    end
    ps = 1'b1;
    step_clk();
    ps = 1'b0;
    n_total++;
    if (duty !== 8'd200 || busy !== 1'b0)
      $display("FAIL jump_commit d=%0d b=%b exp 200/0", duty, busy);
    else n_pass++;
    step_clk();
    n_total++;
    if (duty !== 8'd200)
      $display("FAIL jump_keep d=%0d exp 200", duty);
    else n_pass++;
    m_cur = 200;
    ps = 1'b1;
  endtask

  task automatic test_clamp();
    do_ramp(0, 0, 0, 1000);
    do_ramp(10, 4, 3, 1000);
  endtask

  task automatic test_retarget();
    do_ramp(0, 0, 0, 1000);
    do_ramp(100, 5, 0, 10);
    n_total++;
    if (m_cur != 50)
      $display("FAIL retarget_mid cur=%0d exp 50", m_cur);
    else n_pass++;
    do_ramp(20, 5, 0, 1000);
  endtask

  task automatic test_fault();
    do_ramp(200, 1, 1, 20);
    fault = 1'b1;
    cmd_valid = 1'b1; cmd_duty = 8'd77; cmd_step = 4'd0;
    step_clk();
    n_total++;
    if (duty !== 8'd0 || cmd_ready !== 1'b0 || fault_act !== 1'b1)
      $display("FAIL fault_entry d=%0d r=%b f=%b exp 0/0/1",
               duty, cmd_ready, fault_act);
    else n_pass++;
    fault_clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      n_total++;
      if (fault_act !== 1'b1 || cmd_ready !== 1'b0 || duty !== 8'd0)
        $display("FAIL fault_hold f=%b r=%b d=%0d exp 1/0/0",
                 fault_act, cmd_ready, duty);
      else n_pass++;
    end
    fault = 1'b0; fault_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step_clk();
      n_total++;
      if (fault_act !== 1'b1)
        $display("FAIL fault_sticky f=%b exp 1", fault_act);
      else n_pass++;
    end
    cmd_valid = 1'b0;
    fault_clr = 1'b1;
    step_clk();
    fault_clr = 1'b0;
    n_total++;
    if (fault_act !== 1'b0 || cmd_ready !== 1'b1 || duty !== 8'd0)
      $display("FAIL fault_exit f=%b r=%b d=%0d exp 0/1/0",
               fault_act, cmd_ready, duty);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      n_total++;
      if (duty !== 8'd0 || busy !== 1'b0 || wdog_trip !== 1'b0)
        $display("FAIL fault_after d=%0d b=%b w=%b exp 0/0/0",
                 duty, busy, wdog_trip);
      else n_pass++;
    end
    m_cur = 0;
  endtask

  task automatic test_random();
    int t, s, p, stop;
    for (int it = 0; it < 12; it++) begin
      t = $urandom_range(0, 255);
      s = $urandom_range(0, 15);
      p = $urandom_range(0, 3);
      stop = it[0] ? $urandom_range(1, 30) : 100000;
      do_ramp(t, s, p, stop);
    end
    do_ramp(255, 15, 0, 1000);
    do_ramp(0, 15, 0, 1000);
  endtask

`ifdef PWM_RAMP_WDOG_EN
  task automatic test_wdog();
    presc = '0;
    cmd_valid = 1'b1; cmd_duty = 8'd80; cmd_step = 4'd8;
    step_clk();
    cmd_valid = 1'b0;
    for (int j = 1; j <= 115; j++) begin
      step_clk();
      if (j == 99) begin
        n_total++;
        if (wdog_trip !== 1'b0 || duty !== 8'd80)
          $display("FAIL wdog_pre w=%b d=%0d exp 0/80",
                   wdog_trip, duty);
        else n_pass++;
      end
      if (j == 100) begin
        n_total++;
        if (wdog_trip !== 1'b1)
          $display("FAIL wdog_trip w=%b exp 1", wdog_trip);
        else n_pass++;
      end
    end
    n_total++;
    if (duty !== 8'd0 || busy !== 1'b0 || wdog_trip !== 1'b1)
      $display("FAIL wdog_ramp d=%0d b=%b w=%b exp 0/0/1",
               duty, busy, wdog_trip);
    else n_pass++;
    cmd_valid = 1'b1; cmd_duty = 8'd0; cmd_step = 4'd0;
    step_clk();
    cmd_valid = 1'b0;
    n_total++;
    if (wdog_trip !== 1'b0)
      $display("FAIL wdog_clear w=%b exp 0", wdog_trip);
    else n_pass++;
    m_cur = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_jump();
    test_clamp();
    test_retarget();
    test_fault();
`ifdef PWM_RAMP_WDOG_EN
    test_wdog();
`else
    test_random();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Duty-cycle sequencer that sits in front of the PWM generator. It accepts duty commands over a valid/ready handshake and slews the applied duty toward the target at a programmable step and rate. Duty changes are committed only at PWM period boundaries, and the block forces zero duty on a motor-driver fault.

## Interface
- DUTY_W, 8, width of duty commands and output; matches the generator's duty compare width
- STEP_W, 4, width of the ramp step size
- PRESC_W, 16, width of the ramp-tick prescaler
- WDOG_CYCLES, 24'd10_000_000, command watchdog timeout in CLK cycles (used only with watchdog compiled in)
- CLK  in  1  system clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- CMD_VALID  in  1  duty command valid
- CMD_READY  out  1  command accepted when CMD_VALID && CMD_READY
- CMD_DUTY  in  DUTY_W  target duty
- CMD_STEP  in  STEP_W  ramp step per tick; 0 = jump directly to target
- PRESC  in  PRESC_W  ramp tick every PRESC+1 cycles; held static while BUSY
- PERIOD_START  in  1  one-cycle pulse from the PWM generator at period wrap
- FAULT  in  1  driver fault, level
- FAULT_CLR  in  1  fault clear request, level
- DUTY  out  DUTY_W  duty applied to the PWM generator
- BUSY  out  1  ramp in progress or committed duty pending
- FAULT_ACT  out  1  fault state active
- WDOG_TRIP  out  1  sticky watchdog-timeout flag

## Operation
- States: IDLE, RAMP, FAULT. Internal registers: cur (working duty), tgt, step.
- CMD_READY = 1 in IDLE and RAMP, 0 in FAULT. On accept: tgt<=CMD_DUTY, step<=CMD_STEP, tick counter cleared, state -> RAMP. A new command mid-ramp retargets from the current cur.
- If step==0 on accept: cur<=CMD_DUTY immediately.
- Ramp tick: counter 0..PRESC, pulse when count==PRESC, then count resets. PRESC=0 gives a tick every cycle.
- On tick in RAMP:
  - If cur<tgt: cur<=min(cur+step,tgt).
  - If cur>tgt: cur<=max(cur-step,tgt).
  - Arithmetic in DUTY_W+1 bits, so there is never a wrap past 0 or 2^DUTY_W-1.
- When cur==tgt (after an update or on entry), state -> IDLE.
- DUTY<=cur only in the cycle of PERIOD_START; the duty never changes mid-period.
- BUSY = (state==RAMP) || (cur!=DUTY).
- FAULT=1 in any state:
  - state -> FAULT.
  - cur, tgt and DUTY <= 0 on the next edge, without waiting for PERIOD_START.
  - FAULT_ACT=1.
- Exit from FAULT only when FAULT_CLR=1 && FAULT=0: state -> IDLE, duty stays 0.
- Simultaneous events:
  - Accept and tick in the same cycle: the accept wins and the tick is dropped.
  - FAULT and an accept in the same cycle: FAULT wins and the command is discarded.
  - FAULT and FAULT_CLR together: remain in FAULT.

## Timing
- Reset values (async, RST_N low):
  - DUTY=0, CMD_READY=1, BUSY=0, FAULT_ACT=0, WDOG_TRIP=0.
  - State IDLE; cur, tgt, step and counters all 0.
- Accept to first cur change: PRESC+1 cycles (step>0); same edge as the accept (step==0).
- cur to DUTY: updated on the edge ending a PERIOD_START cycle; DUTY is visible the following cycle.
- FAULT sampled to DUTY=0 and FAULT_ACT=1: 1 cycle.
- Full-scale ramp 0->255, step 1: 255 ticks.

## Configuration
- PWM_RAMP_WDOG_EN defined:
  - A cycle counter clears on every accepted command.
  - On reaching WDOG_CYCLES-1 while tgt!=0: tgt<=0, step<=(step==0 ? 1 : step), state -> RAMP, WDOG_TRIP<=1.
  - WDOG_TRIP clears on the next accepted command.
  - The counter is held in FAULT.
- PWM_RAMP_WDOG_EN undefined: no watchdog counter, WDOG_TRIP tied 0, WDOG_CYCLES ignored.

## Structure
- Shared package pwm_ctrl_pkg:
  - State enum (IDLE, RAMP, FAULT).
  - Default DUTY_W, STEP_W, PRESC_W constants shared with the PWM generator.
- One sub-module pwm_ramp_tick: prescaler counter with PRESC input, clear input and tick output.
- The FSM and duty arithmetic stay in pwm_ramp_ctrl.

## Test plan
- Reset release, then PERIOD_START pulses -> DUTY=0, CMD_READY=1, BUSY=0 throughout.
- Command 200, step 0, PERIOD_START 5 cycles later -> DUTY stays 0 until that pulse, 200 the cycle after, BUSY falls with it.
- Command 10, step 4, PRESC=3 -> cur 4, 8, 10 at 4-cycle intervals; clamps at 10 with no overshoot; state IDLE.
- Ramp 0->100 with step 5; at cur=50 issue command 20 -> cur turns downward 45, 40, … 20.
- Mid-ramp: assert FAULT -> DUTY=0 and CMD_READY=0 next cycle. FAULT_CLR with FAULT=1 -> no exit. Drop FAULT, then FAULT_CLR -> IDLE, DUTY=0.
- With PWM_RAMP_WDOG_EN and WDOG_CYCLES=100, command 80 step 8 then no commands -> after 100 cycles WDOG_TRIP=1 and duty ramps to 0; next command clears WDOG_TRIP.
